// File: rtl/cpu_machine_pkg.sv
// Shared constants for the cpu_machine: datapath widths, opcodes,
// register indices and instruction field positions.
package cpu_machine_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned REG_IDX_W = 3;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS_MSB  = 8;
    localparam int unsigned RS_LSB  = 6;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JNZ = 4'hC;
    localparam logic [3:0] OP_INC = 4'hD;
    localparam logic [3:0] OP_ILL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [REG_IDX_W-1:0] REG_A = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_B = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_C = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_D = 3'd3;
    localparam logic [REG_IDX_W-1:0] REG_E = 3'd4;
    localparam logic [REG_IDX_W-1:0] REG_F = 3'd5;
    localparam logic [REG_IDX_W-1:0] REG_G = 3'd6;
    localparam logic [REG_IDX_W-1:0] REG_H = 3'd7;

endpackage

// File: rtl/cpu_core.sv
// Single-cycle decode/execute: ALU, flags, PC and sticky halt.
// Build option ILLEGAL_HALT_EN: opcode E halts like HLT instead of acting as NOP.
module cpu_core
    import cpu_machine_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  dmem_addr_c,
    output logic [DATA_W-1:0]  dmem_wdata_c,
    output logic               dmem_we_c,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               cpu_halted
);

    logic [ADDR_W-1:0]    pc, pc_nxt;
    logic                 z_flag, c_flag, z_nxt, c_nxt, halt_nxt;
    logic [3:0]           opcode;
    logic [REG_IDX_W-1:0] rd_idx, rs_idx;
    logic [DATA_W-1:0]    imm, rd_val, rs_val;
    logic                 rf_we;
    logic [DATA_W-1:0]    rf_wdata, alu_res;
    logic                 alu_carry;

    assign opcode = imem_data[OPC_MSB:OPC_LSB];
    assign rd_idx = imem_data[RD_MSB:RD_LSB];
    assign rs_idx = imem_data[RS_MSB:RS_LSB];
    assign imm    = imem_data[IMM_MSB:IMM_LSB];

    assign imem_addr    = pc;
    assign dmem_addr_c  = imm;
    assign dmem_wdata_c = rd_val;

    cpu_regfile CPU_regs (
        .clk       (clk),
        .reset     (reset),
        .we        (rf_we),
        .waddr     (rd_idx),
        .wdata     (rf_wdata),
        .raddr_a   (rd_idx),
        .rdata_a_c (rd_val),
        .raddr_b   (rs_idx),
        .rdata_b_c (rs_val)
    );

    // ALU: carry doubles as the SUB borrow; logic ops leave it clear
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode)
            OP_ADD:  {alu_carry, alu_res} = (DATA_W + 1)'(rd_val) + (DATA_W + 1)'(rs_val);
            OP_SUB: begin
                alu_res   = rd_val - rs_val;
                alu_carry = (rd_val < rs_val);
            end
            OP_AND:  alu_res = rd_val & rs_val;
            OP_OR:   alu_res = rd_val | rs_val;
            OP_XOR:  alu_res = rd_val ^ rs_val;
            OP_INC:  {alu_carry, alu_res} = (DATA_W + 1)'(rd_val) + (DATA_W + 1)'(1);
            default: ;
        endcase
    end

    // Next-state decode; a halted core freezes everything
    always_comb begin
        pc_nxt    = pc + ADDR_W'(1);
        z_nxt     = z_flag;
        c_nxt     = c_flag;
        halt_nxt  = cpu_halted;
        rf_we     = 1'b0;
        rf_wdata  = alu_res;
        dmem_we_c = 1'b0;
        if (cpu_halted) begin
            pc_nxt = pc;
        end else begin
            case (opcode)
                OP_LDI: begin
                    rf_we    = 1'b1;
                    rf_wdata = imm;
                end
                OP_MOV: begin
                    rf_we    = 1'b1;
                    rf_wdata = rs_val;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC: begin
                    rf_we = 1'b1;
                    z_nxt = (alu_res == '0);
                    c_nxt = alu_carry;
                end
                OP_LD: begin
                    rf_we    = 1'b1;
                    rf_wdata = dmem_rdata;
                end
                OP_ST:  dmem_we_c = !reset;
                OP_JMP: pc_nxt = imm;
                OP_JZ:  if (z_flag)  pc_nxt = imm;
                OP_JNZ: if (!z_flag) pc_nxt = imm;
`ifdef ILLEGAL_HALT_EN
                OP_ILL: begin
                    halt_nxt = 1'b1;
                    pc_nxt   = pc;
                end
`endif
                OP_HLT: begin
                    halt_nxt = 1'b1;
                    pc_nxt   = pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            z_flag     <= 1'b0;
            c_flag     <= 1'b0;
            cpu_halted <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            z_flag     <= z_nxt;
            c_flag     <= c_nxt;
            cpu_halted <= halt_nxt;
        end
    end

endmodule

// File: rtl/cpu_regfile.sv
// Eight named 8-bit registers A..H (G is the temp register):
// one write port, two combinational read ports.
module cpu_regfile
    import cpu_machine_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a_c,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b_c
);

    logic [DATA_W-1:0] regA, regB, regC, regD, regE, regF, regG, regH;

    always_ff @(posedge clk) begin
        if (reset) begin
            regA <= '0; regB <= '0; regC <= '0; regD <= '0;
            regE <= '0; regF <= '0; regG <= '0; regH <= '0;
        end else if (we) begin
            case (waddr)
                REG_A: regA <= wdata;
                REG_B: regB <= wdata;
                REG_C: regC <= wdata;
                REG_D: regD <= wdata;
                REG_E: regE <= wdata;
                REG_F: regF <= wdata;
                REG_G: regG <= wdata;
                REG_H: regH <= wdata;
            endcase
        end
    end

    always_comb begin
        case (raddr_a)
            REG_A: rdata_a_c = regA;
            REG_B: rdata_a_c = regB;
            REG_C: rdata_a_c = regC;
            REG_D: rdata_a_c = regD;
            REG_E: rdata_a_c = regE;
            REG_F: rdata_a_c = regF;
            REG_G: rdata_a_c = regG;
            REG_H: rdata_a_c = regH;
        endcase
    end

    always_comb begin
        case (raddr_b)
            REG_A: rdata_b_c = regA;
            REG_B: rdata_b_c = regB;
            REG_C: rdata_b_c = regC;
            REG_D: rdata_b_c = regD;
            REG_E: rdata_b_c = regE;
            REG_F: rdata_b_c = regF;
            REG_G: rdata_b_c = regG;
            REG_H: rdata_b_c = regH;
        endcase
    end

endmodule

// File: rtl/mem_array.sv
// Generic memory: combinational read, write at the rising edge.
// Contents are never cleared by reset.
module mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] Memory [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            Memory[addr] <= wdata;
        end
    end

    assign rdata_c = Memory[addr];

endmodule

// File: rtl/cpu_machine.sv
// Board-level 8-bit computer: core plus 256x16 instruction and 256x8 data memories.
// Build option ILLEGAL_HALT_EN (see cpu_core) selects halting on opcode E.
module cpu_machine
    import cpu_machine_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    output logic halted
);

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [ADDR_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata, dmem_rdata;
    logic               dmem_we;
    logic               cpu_halted;

    mem_array #(.DEPTH(IMEM_DEPTH), .WIDTH(INSTR_W), .AW(ADDR_W)) I_MEM (
        .clk     (clk),
        .we      (1'b0),
        .addr    (imem_addr),
        .wdata   (INSTR_W'(0)),
        .rdata_c (imem_data)
    );

    mem_array #(.DEPTH(DMEM_DEPTH), .WIDTH(DATA_W), .AW(ADDR_W)) D_MEM (
        .clk     (clk),
        .we      (dmem_we),
        .addr    (dmem_addr),
        .wdata   (dmem_wdata),
        .rdata_c (dmem_rdata)
    );

    cpu_core CPU_ (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .dmem_addr_c  (dmem_addr),
        .dmem_wdata_c (dmem_wdata),
        .dmem_we_c    (dmem_we),
        .dmem_rdata   (dmem_rdata),
        .cpu_halted   (cpu_halted)
    );

    assign halted = cpu_halted;

endmodule

// File: tb/tb_cpu_machine.sv
// Bench for cpu_machine: an instruction-level model steps on every edge and the
// architectural state is compared each cycle, plus hand-computed program results.
module tb_cpu_machine;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic reset  = 1'b1;
    logic halted;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [15:0] prog [$];
    logic [15:0] m_imem [256];
    logic [7:0]  m_dmem [256];
    logic [7:0]  m_regs [8];
    int          m_pc;
    bit          m_z, m_c, m_halted;

    logic [15:0] s_ins;
    int          s_op, s_rd, s_rs, s_a, s_b, s_r, s_nxt;
    logic [7:0]  s_imm;

    int edges, total;

    cpu_machine dut (
        .clk    (clk),
        .reset  (reset),
        .halted (halted)
    );

    // Gated clock: edges only while clk_en is high
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_ri(input int op, input int rd, input int imm);
        return {4'(op), 3'(rd), 1'b0, 8'(imm)};
    endfunction

    function automatic logic [15:0] enc_rr(input int op, input int rd, input int rs);
        return {4'(op), 3'(rd), 3'(rs), 6'd0};
    endfunction

    // Instruction-level reference: ISA semantics in plain integer arithmetic
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0; m_z = 0; m_c = 0; m_halted = 0;
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        end else if (!m_halted) begin
            s_ins = m_imem[m_pc];
            s_op  = int'(s_ins[15:12]);
            s_rd  = int'(s_ins[11:9]);
            s_rs  = int'(s_ins[8:6]);
            s_imm = s_ins[7:0];
            s_a   = int'(m_regs[s_rd]);
            s_b   = int'(m_regs[s_rs]);
            s_nxt = (m_pc + 1) % 256;
            case (s_op)
                1: m_regs[s_rd] = s_imm;
                2: m_regs[s_rd] = m_regs[s_rs];
                3: begin s_r = s_a + s_b; m_c = (s_r > 255); s_r = s_r % 256;
                         m_regs[s_rd] = 8'(s_r); m_z = (s_r == 0); end
                4: begin m_c = (s_a < s_b); s_r = (s_a - s_b + 256) % 256;
                         m_regs[s_rd] = 8'(s_r); m_z = (s_r == 0); end
                5: begin s_r = s_a & s_b; m_c = 0; m_regs[s_rd] = 8'(s_r); m_z = (s_r == 0); end
                6: begin s_r = s_a | s_b; m_c = 0; m_regs[s_rd] = 8'(s_r); m_z = (s_r == 0); end
                7: begin s_r = s_a ^ s_b; m_c = 0; m_regs[s_rd] = 8'(s_r); m_z = (s_r == 0); end
                8: m_regs[s_rd] = m_dmem[s_imm];
                9: m_dmem[s_imm] = m_regs[s_rd];
                10: s_nxt = int'(s_imm);
                11: if (m_z)  s_nxt = int'(s_imm);
                12: if (!m_z) s_nxt = int'(s_imm);
                13: begin s_r = s_a + 1; m_c = (s_r > 255); s_r = s_r % 256;
                          m_regs[s_rd] = 8'(s_r); m_z = (s_r == 0); end
                14: begin
`ifdef ILLEGAL_HALT_EN
                    m_halted = 1; s_nxt = m_pc;
`endif
                end
                15: begin m_halted = 1; s_nxt = m_pc; end
                default: ;
            endcase
            m_pc = s_nxt;
        end
    end

    // Per-cycle comparison of architectural state against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state",
                  {dut.CPU_.pc, halted, dut.CPU_.z_flag, dut.CPU_.c_flag,
                   dut.CPU_.CPU_regs.regA, dut.CPU_.CPU_regs.regB, dut.CPU_.CPU_regs.regC,
                   dut.CPU_.CPU_regs.regD, dut.CPU_.CPU_regs.regE, dut.CPU_.CPU_regs.regF,
                   dut.CPU_.CPU_regs.regG, dut.CPU_.CPU_regs.regH, dut.D_MEM.Memory[16]},
                  {8'(m_pc), m_halted, m_z, m_c, m_regs[0], m_regs[1], m_regs[2], m_regs[3],
                   m_regs[4], m_regs[5], m_regs[6], m_regs[7], m_dmem[16]});
        end
    end

    task automatic load_prog();
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = (i < prog.size()) ? prog[i] : 16'h0000;
            m_imem[i] = w;
            dut.I_MEM.Memory[i] = w;
        end
    endtask

    // Called at a negedge with the clock running: reload under reset, release after one edge
    task automatic restart();
        reset = 1'b1;
        load_prog();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input int max_edges, output int n);
        n = 0;
        while (n < max_edges && halted !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [63:0] dut_regs();
        return {dut.CPU_.CPU_regs.regA, dut.CPU_.CPU_regs.regB, dut.CPU_.CPU_regs.regC,
                dut.CPU_.CPU_regs.regD, dut.CPU_.CPU_regs.regE, dut.CPU_.CPU_regs.regF,
                dut.CPU_.CPU_regs.regG, dut.CPU_.CPU_regs.regH};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_dmem[i] = 8'h00;
            dut.D_MEM.Memory[i] = 8'h00;
        end

        // LDI A,5; LDI B,3; ADD A,B; HLT -- preloaded before the clock starts
        prog = '{enc_ri(1, 0, 8'h05), enc_ri(1, 1, 8'h03), enc_rr(3, 0, 1), 16'hF000};
        load_prog();
        #20;
        clk_en = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_pc", 96'(dut.CPU_.pc), 96'h0);
        check("reset_regs", 96'(dut_regs()), 96'h0);
        check("reset_halted", 96'(halted), 96'h0);
        reset = 1'b0;
        run_to_halt(50, edges);
        check("t1_edges", 96'(edges), 96'd4);
        check("t1_regs", 96'(dut_regs()), 96'h08_03_00_00_00_00_00_00);
        check("t1_zc", 96'({dut.CPU_.z_flag, dut.CPU_.c_flag}), 96'h0);
        check("t1_model_a", 96'(m_regs[0]), 96'h08);

        // LDI A,0xFF; INC A; HLT
        prog = '{enc_ri(1, 0, 8'hFF), enc_rr(13, 0, 0), 16'hF000};
        restart();
        run_to_halt(50, edges);
        check("t2_edges", 96'(edges), 96'd3);
        check("t2_a", 96'(dut.CPU_.CPU_regs.regA), 96'h00);
        check("t2_zc", 96'({dut.CPU_.z_flag, dut.CPU_.c_flag}), 96'h3);

        // LDI C,0x2A; ST C,[0x10]; LD D,[0x10]; HLT
        prog = '{enc_ri(1, 2, 8'h2A), enc_ri(9, 2, 8'h10), enc_ri(8, 3, 8'h10), 16'hF000};
        restart();
        run_to_halt(50, edges);
        check("t3_edges", 96'(edges), 96'd4);
        check("t3_d", 96'(dut.CPU_.CPU_regs.regD), 96'h2A);
        check("t3_dmem", 96'(dut.D_MEM.Memory[16]), 96'h2A);
        check("t3_model_d", 96'(m_regs[3]), 96'h2A);

        // LDI A,3; LDI B,1; SUB A,B; JNZ 2; HLT -- with a clock pause mid-loop
        prog = '{enc_ri(1, 0, 3), enc_ri(1, 1, 1), enc_rr(4, 0, 1), enc_ri(12, 0, 2), 16'hF000};
        restart();
        repeat (3) @(negedge clk);
        clk_en = 1'b0;
        #57;
        check("t4_pause_pc", 96'(dut.CPU_.pc), 96'd3);
        check("t4_pause_a", 96'(dut.CPU_.CPU_regs.regA), 96'h02);
        clk_en = 1'b1;
        run_to_halt(50, edges);
        total = edges + 3;
        check("t4_edges", 96'(total), 96'd9);
        check("t4_a_z", 96'({dut.CPU_.CPU_regs.regA, dut.CPU_.z_flag}), 96'h001);

        // 20 edges while halted: nothing moves; then a single reset edge
        repeat (20) @(negedge clk);
        check("t5_pc", 96'(dut.CPU_.pc), 96'd4);
        check("t5_regs", 96'(dut_regs()), 96'h00_01_00_00_00_00_00_00);
        check("t5_halted", 96'(halted), 96'h1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_regs", 96'(dut_regs()), 96'h0);
        check("t5_rst_halted", 96'(halted), 96'h0);
        check("t5_rst_pc", 96'(dut.CPU_.pc), 96'h0);
        reset = 1'b0;
        @(negedge clk);
        check("t5_resume_pc", 96'(dut.CPU_.pc), 96'd1);

        // Opcode E; LDI A,0x11; HLT
        prog = '{16'hE000, enc_ri(1, 0, 8'h11), 16'hF000};
        restart();
        run_to_halt(50, edges);
`ifdef ILLEGAL_HALT_EN
        check("t6_edges", 96'(edges), 96'd1);
        check("t6_a", 96'(dut.CPU_.CPU_regs.regA), 96'h00);
`else
        check("t6_edges", 96'(edges), 96'd3);
        check("t6_a", 96'(dut.CPU_.CPU_regs.regA), 96'h11);
`endif
        check("t6_halted", 96'(halted), 96'h1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
